// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one ALUController+ALU pair between NREQ
// requesters. A round-robin pick in IDLE registers the winner's operation,
// EXEC drives it onto the shared ALU for one cycle, and RESP hands the
// captured result/zero back to the winner.
//
// Handshakes (both sides): a transfer happens in a cycle where valid and
// ready are both high at the rising edge; valid never waits on ready.
// Requests: req_ready is asserted combinationally for at most one requester
// and only while IDLE, so the request handshake completes in that cycle.
// Responses: resp_valid[gid] holds with stable resp_data/resp_zero until
// resp_ready[gid] is seen; ready bits of other requesters are ignored.
module alu_share_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [2*NREQ-1:0]       req_aluop,
    input  logic [7*NREQ-1:0]       req_funct7,
    input  logic [3*NREQ-1:0]       req_funct3,
    input  logic [WIDTH*NREQ-1:0]   req_a,
    input  logic [WIDTH*NREQ-1:0]   req_b,
    output logic [1:0]              alu_aluop,
    output logic [6:0]              alu_funct7,
    output logic [2:0]              alu_funct3,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    input  logic [WIDTH-1:0]        alu_result,
    input  logic                    alu_zero,
    output logic [NREQ-1:0]         resp_valid,
    input  logic [NREQ-1:0]         resp_ready,
    output logic [WIDTH-1:0]        resp_data,
    output logic                    resp_zero,
    output logic                    busy,
    // FSM state for observation: 0 = IDLE, 1 = EXEC, 2 = RESP
    output logic [1:0]              dbg_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gid;
    logic [1:0]       aluop_q;
    logic [6:0]       funct7_q;
    logic [2:0]       funct3_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    logic             found;
    logic [PW-1:0]    win;
    logic [PW-1:0]    ptr_nxt;
    int               scan_idx;
    logic             accept;
    logic             resp_take;

    logic [1:0]       sel_aluop;
    logic [6:0]       sel_funct7;
    logic [2:0]       sel_funct3;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Round-robin scan: first valid requester starting at ptr, wrapping mod NREQ
    always_comb begin
        found    = 1'b0;
        win      = '0;
        scan_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = (int'(ptr) + k) % NREQ;
            if (!found && req_valid[scan_idx]) begin
                found = 1'b1;
                win   = PW'(scan_idx);
            end
        end
    end

    // Pointer moves just past the winner so it becomes lowest priority next time
    always_comb begin
        ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    end

    // Mux out the winner's packed request fields
    always_comb begin
        sel_aluop  = req_aluop[2*int'(win) +: 2];
        sel_funct7 = req_funct7[7*int'(win) +: 7];
        sel_funct3 = req_funct3[3*int'(win) +: 3];
        sel_a      = req_a[WIDTH*int'(win) +: WIDTH];
        sel_b      = req_b[WIDTH*int'(win) +: WIDTH];
    end

    // One-hot request/response strobes derived from state and grant
    always_comb begin
        accept    = (state == S_IDLE) && found;
        resp_take = (state == S_RESP) && resp_ready[gid];
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i]  = accept && (win == PW'(i));
            resp_valid[i] = (state == S_RESP) && (gid == PW'(i));
        end
    end

    // FSM, grant bookkeeping, operation registers and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= '0;
            gid      <= '0;
            aluop_q  <= '0;
            funct7_q <= '0;
            funct3_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        aluop_q  <= sel_aluop;
                        funct7_q <= sel_funct7;
                        funct3_q <= sel_funct3;
                        a_q      <= sel_a;
                        b_q      <= sel_b;
                        gid      <= win;
                        ptr      <= ptr_nxt;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_q <= alu_result;
                    zero_q   <= alu_zero;
                    state    <= S_RESP;
                end
                S_RESP: begin
                    if (resp_take) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Shared ALU is fed from the registers in every state; results held outside RESP
    always_comb begin
        alu_aluop  = aluop_q;
        alu_funct7 = funct7_q;
        alu_funct3 = funct3_q;
        alu_a      = a_q;
        alu_b      = b_q;
        resp_data  = result_q;
        resp_zero  = zero_q;
        busy       = (state != S_IDLE);
        dbg_state  = state;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model (round-robin pick, fixed 2-cycle
// response latency, result computed from the submitted fields).
module tb_alu_share_arbiter;

  localparam int NREQ  = 2;
  localparam int WIDTH = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_aluop = '0;
  logic [7*NREQ-1:0]     req_funct7 = '0;
  logic [3*NREQ-1:0]     req_funct3 = '0;
  logic [WIDTH*NREQ-1:0] req_a = '0;
  logic [WIDTH*NREQ-1:0] req_b = '0;
  logic [1:0]            alu_aluop;
  logic [6:0]            alu_funct7;
  logic [2:0]            alu_funct3;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [WIDTH-1:0]      alu_result;
  logic                  alu_zero;
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ready = '0;
  logic [WIDTH-1:0]      resp_data;
  logic                  resp_zero;
  logic                  busy;
  logic [1:0]            dbg_state;

  alu_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_funct7(req_funct7), .req_funct3(req_funct3),
    .req_a(req_a), .req_b(req_b),
    .alu_aluop(alu_aluop), .alu_funct7(alu_funct7), .alu_funct3(alu_funct3),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_zero(resp_zero),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- ALU behaviour (stub ALU and reference model) ----------------
  function automatic logic [WIDTH-1:0] alu_ref(input logic [1:0] op, input logic [6:0] f7,
                                               input logic [2:0] f3, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      default: begin
        case (f3)
          3'b000: return (f7 == 7'b0100000) ? a - b : a + b;
          3'b111: return a & b;
          3'b110: return a | b;
          3'b100: return a ^ b;
          default: return a + b;
        endcase
      end
    endcase
  endfunction

  always_comb alu_result = alu_ref(alu_aluop, alu_funct7, alu_funct3, alu_a, alu_b);
  assign alu_zero = (alu_result == '0);

  // ---------------- requester driver ----------------
  logic [1:0]       f_aluop[NREQ];
  logic [6:0]       f_f7[NREQ];
  logic [2:0]       f_f3[NREQ];
  logic [WIDTH-1:0] f_a[NREQ];
  logic [WIDTH-1:0] f_b[NREQ];

  int total = 0;
  int bad = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic drive_fields();
    for (int i = 0; i < NREQ; i++) begin
      req_aluop[2*i +: 2]      = f_aluop[i];
      req_funct7[7*i +: 7]     = f_f7[i];
      req_funct3[3*i +: 3]     = f_f3[i];
      req_a[WIDTH*i +: WIDTH]  = f_a[i];
      req_b[WIDTH*i +: WIDTH]  = f_b[i];
    end
  endtask

  task automatic set_fields(input int i, input logic [1:0] op, input logic [6:0] f7,
                            input logic [2:0] f3, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b);
    f_aluop[i] = op; f_f7[i] = f7; f_f3[i] = f3; f_a[i] = a; f_b[i] = b;
    drive_fields();
  endtask

  task automatic rand_fields(input int i);
    logic [2:0] f3;
    logic [WIDTH-1:0] a;
    case ($urandom_range(0, 3))
      0: f3 = 3'b000;
      1: f3 = 3'b111;
      2: f3 = 3'b110;
      default: f3 = 3'b100;
    endcase
    a = $urandom;
    set_fields(i, 2'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0,
               f3, a, ($urandom_range(0, 3) == 0) ? a : WIDTH'($urandom));
  endtask

  function automatic logic [WIDTH-1:0] exp_res(input int i);
    return alu_ref(f_aluop[i], f_f7[i], f_f3[i], f_a[i], f_b[i]);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // round-robin pick: first valid requester at p, p+1, ... mod NREQ (-1 if none)
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic do_reset();
    req_valid = '0;
    resp_ready = '0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (resp_valid !== '0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    total++; if (resp_data !== '0) begin bad++; $display("FAIL reset_resp_data got=%0h exp=0", resp_data); end
    total++; if (alu_a !== '0) begin bad++; $display("FAIL reset_alu_a got=%0h exp=0", alu_a); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_fields(0, 2'b10, 7'b0, 3'b000, 32'd3, 32'd4);
    req_valid = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rst_pre_accept got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b0;  // abort while EXEC
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (resp_valid !== '0) begin bad++; $display("FAIL abort_resp_valid got=%b exp=0", resp_valid); end
    total++; if (alu_a !== '0) begin bad++; $display("FAIL abort_alu_a got=%0h exp=0", alu_a); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL abort_state got=%0d exp=0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      total++; if (resp_valid !== '0) begin bad++; $display("FAIL abort_no_resp cyc=%0d got=%b exp=0", c, resp_valid); end
    end
  endtask

  task automatic test_single_op();
    do_reset();
    set_fields(0, 2'b10, 7'b0, 3'b000, 32'd5, 32'd7);
    req_valid = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_req_ready got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    total++; if (resp_valid !== '0) begin bad++; $display("FAIL single_t1_resp got=%b exp=00", resp_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_t1_busy got=%b exp=1", busy); end
    total++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_aluop !== 2'b10)
      begin bad++; $display("FAIL single_alu_drive got a=%0d b=%0d op=%b exp a=5 b=7 op=10", alu_a, alu_b, alu_aluop); end
    @(negedge clk); #1;
    total++; if (resp_valid !== 2'b01) begin bad++; $display("FAIL single_t2_resp got=%b exp=01", resp_valid); end
    total++; if (resp_data !== 32'd12) begin bad++; $display("FAIL single_data got=%0d exp=12", resp_data); end
    total++; if (resp_zero !== 1'b0) begin bad++; $display("FAIL single_zero got=%b exp=0", resp_zero); end
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = '0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_done_busy got=%b exp=0", busy); end
    total++; if (resp_data !== 32'd12) begin bad++; $display("FAIL single_hold_data got=%0d exp=12", resp_data); end
  endtask

  task automatic test_contention();
    int exp_g;
    int mptr;
    bit seen;
    do_reset();
    mptr = 0;
    rand_fields(0);
    rand_fields(1);
    req_valid = 2'b11;
    resp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = rr_pick(req_valid, mptr);
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        #1;
        if (req_ready !== '0) seen = 1'b1;
        else @(negedge clk);
      end
      total++;
      if (!seen) begin bad++; $display("FAIL contention_timeout op=%0d got=%b exp=grant", k, req_ready); return; end
      total++; if (req_ready !== onehot(k % 2) || exp_g != k % 2)
        begin bad++; $display("FAIL contention_grant op=%0d got=%b exp=%b", k, req_ready, onehot(k % 2)); end
      exp_q.push_back(exp_res(exp_g));
      mptr = (exp_g + 1) % NREQ;
      @(posedge clk); #1;
      rand_fields(exp_g);  // new request from the same requester, still valid
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk); #1;
        if (resp_valid !== '0) seen = 1'b1;
      end
      total++;
      if (!seen) begin bad++; $display("FAIL contention_resp_timeout op=%0d", k); return; end
      total++; if (resp_valid !== onehot(exp_g) || resp_data !== exp_q[0])
        begin bad++; $display("FAIL contention_resp op=%0d got v=%b d=%0h exp v=%b d=%0h", k, resp_valid, resp_data, onehot(exp_g), exp_q[0]); end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    req_valid = '0;
    resp_ready = '0;
  endtask

  task automatic test_backpressure_wrong_ready();
    logic [WIDTH-1:0] e0, e1;
    do_reset();
    set_fields(0, 2'b00, 7'b0, 3'b000, 32'd100, 32'd23);
    e0 = exp_res(0);
    req_valid = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL bp_accept0 got=%b exp=01", req_ready); end
    @(negedge clk);
    set_fields(1, 2'b10, 7'b0, 3'b111, 32'hF0F0, 32'h0FF0);
    e1 = exp_res(1);
    req_valid = 2'b10;
    #1;
    total++; if (req_ready !== '0) begin bad++; $display("FAIL bp_exec_ready got=%b exp=00", req_ready); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      total++; if (resp_valid !== 2'b01 || resp_data !== e0 || dbg_state !== 2'd2 || req_ready !== '0)
        begin bad++; $display("FAIL bp_hold cyc=%0d got v=%b d=%0d st=%0d rr=%b exp v=01 d=%0d st=2 rr=00", c, resp_valid, resp_data, dbg_state, req_ready, e0); end
    end
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = '0;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_accept1 got=%b exp=10", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    total++; if (resp_valid !== 2'b10 || resp_data !== e1)
      begin bad++; $display("FAIL wr_resp got v=%b d=%0h exp v=10 d=%0h", resp_valid, resp_data, e1); end
    resp_ready = 2'b01;  // wrong requester
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      total++; if (resp_valid !== 2'b10 || dbg_state !== 2'd2)
        begin bad++; $display("FAIL wr_ignored cyc=%0d got v=%b st=%0d exp v=10 st=2", c, resp_valid, dbg_state); end
    end
    resp_ready = 2'b10;
    @(negedge clk);
    resp_ready = '0;
    #1;
    total++; if (busy !== 1'b0 || resp_valid !== '0)
      begin bad++; $display("FAIL wr_taken got busy=%b v=%b exp busy=0 v=00", busy, resp_valid); end
  endtask

  task automatic test_zero_flag();
    do_reset();
    set_fields(0, 2'b10, 7'b0100000, 3'b000, 32'd9, 32'd9);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    total++; if (resp_data !== '0 || resp_zero !== 1'b1)
      begin bad++; $display("FAIL zero_flag got d=%0d z=%b exp d=0 z=1", resp_data, resp_zero); end
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = '0;
    total++; if (resp_zero !== 1'b1) begin bad++; $display("FAIL zero_hold got=%b exp=1", resp_zero); end
  endtask

  task automatic test_random();
    int mptr, gid, age, g;
    bit inflight;
    bit consumed[NREQ];
    logic [WIDTH-1:0] last;
    logic [NREQ-1:0] exp_rr;
    do_reset();
    mptr = 0; inflight = 1'b0; age = 0; gid = 0; last = '0;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) consumed[i] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (consumed[i] || !req_valid[i]) begin
          rand_fields(i);
          req_valid[i] = ($urandom_range(0, 2) != 0);
          consumed[i] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      #1;
      if (!inflight) begin
        g = rr_pick(req_valid, mptr);
        exp_rr = onehot(g);
        total++; if (req_ready !== exp_rr || resp_valid !== '0 || resp_data !== last)
          begin bad++; $display("FAIL rand_idle cyc=%0d got rr=%b v=%b d=%0h exp rr=%b v=00 d=%0h", cyc, req_ready, resp_valid, resp_data, exp_rr, last); end
        if (g >= 0) begin
          inflight = 1'b1; age = 0; gid = g;
          exp_q.push_back(exp_res(g));
          mptr = (g + 1) % NREQ;
          consumed[g] = 1'b1;
        end
      end else begin
        age++;
        if (age == 1) begin
          total++; if (req_ready !== '0 || resp_valid !== '0 || busy !== 1'b1)
            begin bad++; $display("FAIL rand_exec cyc=%0d got rr=%b v=%b b=%b exp rr=00 v=00 b=1", cyc, req_ready, resp_valid, busy); end
        end else begin
          total++; if (req_ready !== '0 || resp_valid !== onehot(gid) || resp_data !== exp_q[0] || resp_zero !== (exp_q[0] == '0))
            begin bad++; $display("FAIL rand_resp cyc=%0d got rr=%b v=%b d=%0h z=%b exp rr=00 v=%b d=%0h", cyc, req_ready, resp_valid, resp_data, resp_zero, onehot(gid), exp_q[0]); end
          if (resp_ready[gid]) begin
            last = exp_q.pop_front();
            inflight = 1'b0;
          end
        end
      end
    end
    req_valid = '0;
    resp_ready = '0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < NREQ; i++) set_fields(i, 2'b00, 7'b0, 3'b000, '0, '0);
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure_wrong_ready();
    test_zero_flag();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
